mix_columns_seq: RTL
====================

# mix_columns_seq

Sequential AES MixColumns engine for the encryption datapath. It is the forward counterpart of the decryption-side inverse MixColumns stage. It accepts a 128-bit AES state over a valid/ready handshake and processes one column per clock through a single shared column multiplier. It holds the 128-bit result until the downstream stage accepts it. It sits between ShiftRows and AddRoundKey in the iterative encryption round.

## Interface
- No parameters. The state width is fixed at 128 bits and there are 4 columns.
- `clk`  in  1  Single clock. All flops update on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `in`  in  [0:127]  Input state. Byte k = `in[8k:8k+7]`. Column c = bytes 4c..4c+3. Row r of column c = byte 4c+r.
- `in_valid`  in  1  `in` holds a valid state.
- `in_ready`  out  1  The block can accept a state. It is high only in IDLE.
- `out`  out  [0:127]  Result state. It uses the same byte and column layout as `in`.
- `out_valid`  out  1  `out` holds a complete result.
- `out_ready`  in  1  Downstream accepts `out`.
- `busy`  out  1  High in BUSY and DONE.

## Operation
- Per-column transform, with a0..a3 as the input column rows and all additions as XOR:
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- GF(2^8) arithmetic:
  - xtime(x) = {x[1:7],0}, XORed with 8'h1b when the MSB x[0] = 1.
  - 3·x = xtime(x) ^ x.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready` = 1. When `in_valid` = 1 at an edge, load `in` into the source register, set `col` = 0 and go to BUSY. `out` and `out_valid` are not changed by the load.
  - BUSY: each edge writes the transformed column `col` into `out[32·col +: 32]` and increments `col`. At `col` = 3 the state goes to DONE and `out_valid` goes to 1. `in_valid` is ignored in this state.
  - DONE: `out` and `out_valid` are held stable. When `out_ready` = 1 at an edge, `out_valid` goes to 0 and the state goes to IDLE. `in_ready` stays 0 throughout DONE, so no new state is accepted in the same cycle.
- Widths:
  - `col` is a 2-bit counter and wraps to 0 after 3.
  - The source register is 128 bits and is captured only on acceptance.
  - A change on `in` after acceptance has no effect on the current operation.

## Timing
- Reset values, taking effect on the first edge with `rst` = 1:
  - state = IDLE, `col` = 0.
  - `out` = 128'h0, `out_valid` = 0, `in_ready` = 1, `busy` = 0.
- Reset has priority over every other event. A reset during BUSY or DONE abandons the operation: `out` is cleared and no `out_valid` pulse is produced.
- Latency:
  - Acceptance edge E, then column 0 is written at E+1 and column 3 at E+4.
  - `out_valid` = 1 in the cycle after edge E+4, which is 4 cycles after acceptance.
- Throughput: at best one state per 6 cycles (1 accept, 4 compute, 1 output handshake).
- Backpressure: DONE is held indefinitely while `out_ready` = 0. If `out_ready` is already high when `out_valid` rises, the handshake completes on the next edge.
- During BUSY, `out` is partially updated. Its value is defined only while `out_valid` = 1.

## Structure
- Shared AES package contents:
  - `AES_RED_POLY` = 8'h1b.
  - Functions `xtime` and `gmul3`.
  - Byte/column index helpers.
  - The state-type typedef (`logic [0:127]`) and the FSM state enum.
- Sub-module `mix_column_word`: purely combinational, mapping one 32-bit column to one 32-bit column. It is instantiated once and time-shared across the 4 columns, with its input muxed by `col`.

## Test plan
- FIPS-197 round-1 state:
  - Input `d4bf5d30e0b452aeb84111f11e2798e5` -> `out` = `046681e5e0cb199a48f8d37a2806264c`.
  - `out_valid` rises exactly 4 cycles after acceptance.
- Known-answer columns:
  - Input `db135345f20a225c01010101c6c6c6c6` -> `8e4da1bc9fdc589d01010101c6c6c6c6`.
  - Input `d4d4d4d52d26314c` in columns 0-1 -> columns `d5d5d7d6` and `4d7ebdf8`.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles after `out_valid`.
  - `out` stays stable, `in_ready` stays 0, and a pulsed `in_valid` in that window is ignored.
  - Raising `out_ready` returns the block to IDLE on the next edge.
- Reset mid-operation:
  - Assert `rst` at the second BUSY edge -> next cycle `out` = 0, `out_valid` = 0, `in_ready` = 1.
  - A following state then completes correctly.
- Back-to-back:
  - Keep `in_valid` and `out_ready` high with states A and B queued.
  - Acceptances occur 6 cycles apart and both results match the reference model.
  - `in` is changed during BUSY with no effect on the result.

Source files
------------

// File: rtl/mix_columns_seq_pkg.sv
// mix_columns_seq_pkg
// Shared AES definitions for the encryption-side MixColumns engine:
//   - AES_RED_POLY : GF(2^8) reduction constant (x^8 = x^4 + x^3 + x + 1)
//   - state_t / word_t / byte_t : big-endian-indexed state, column and byte types
//   - fsm_state_e  : IDLE / BUSY / DONE controller states
//   - xtime, gmul3 : GF(2^8) multiply by 2 and by 3
//   - col_base, word_byte : byte/column index helpers for the [0:127] layout
package mix_columns_seq_pkg;

    typedef logic [0:127] state_t;
    typedef logic [0:31]  word_t;
    typedef logic [0:7]   byte_t;

    localparam byte_t AES_RED_POLY = 8'h1b;
    localparam int    NUM_COLS     = 4;
    localparam int    COL_W        = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_state_e;

    // Multiply by 2 in GF(2^8); bit 0 is the MSB in this layout.
    function automatic byte_t xtime(input byte_t x);
        return {x[1:7], 1'b0} ^ (x[0] ? AES_RED_POLY : 8'h00);
    endfunction

    // Multiply by 3 in GF(2^8): 2x + x.
    function automatic byte_t gmul3(input byte_t x);
        return xtime(x) ^ x;
    endfunction

    // First bit index of column c inside a 128-bit state (32*c).
    function automatic logic [6:0] col_base(input logic [1:0] c);
        return {c, 5'b00000};
    endfunction

    // Row r of a 32-bit column word.
    function automatic byte_t word_byte(input word_t w, input logic [1:0] r);
        return w[{r, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// mix_column_word
// Purely combinational AES MixColumns transform of a single column.
// Ports:
//   col_in  [0:31] : input column, row r = col_in[8r +: 8]
//   col_out [0:31] : transformed column, same row layout
module mix_column_word
    import mix_columns_seq_pkg::*;
(
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;

    // Multiply the column by the fixed circulant matrix [2 3 1 1].
    always_comb begin
        a0 = word_byte(col_in, 2'd0);
        a1 = word_byte(col_in, 2'd1);
        a2 = word_byte(col_in, 2'd2);
        a3 = word_byte(col_in, 2'd3);
        b0 = xtime(a0) ^ gmul3(a1) ^ a2        ^ a3;
        b1 = a0        ^ xtime(a1) ^ gmul3(a2) ^ a3;
        b2 = a0        ^ a1        ^ xtime(a2) ^ gmul3(a3);
        b3 = gmul3(a0) ^ a1        ^ a2        ^ xtime(a3);
        col_out = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq
// Sequential AES MixColumns: accepts a 128-bit state, runs one column per
// clock through a single shared column multiplier, then holds the result
// until downstream accepts it.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in [0:127]        : input state (column c = bits 32c +: 32)
//   in_valid/in_ready : input handshake, in_ready high only in IDLE
//   out [0:127]       : result state, valid while out_valid is high
//   out_valid/out_ready : output handshake
//   busy              : high while computing or holding a result
module mix_columns_seq
    import mix_columns_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    fsm_state_e  state_q,     state_d;
    logic [1:0]  col_q,       col_d;
    state_t      src_q,       src_d;
    state_t      out_q,       out_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q,  in_ready_d;
    logic        busy_q,      busy_d;

    word_t       word_in;
    word_t       word_out;

    // The single column multiplier is time-shared; col selects its source.
    always_comb begin
        word_in = src_q[col_base(col_q) +: COL_W];
    end

    mix_column_word u_word (
        .col_in  (word_in),
        .col_out (word_out)
    );

    // Next-state logic. The source register is captured only on acceptance,
    // so later changes on 'in' cannot disturb a running operation.
    // in_ready and busy are derived from the next state so they are
    // registered alongside it.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        src_d       = src_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_d[col_base(col_q) +: COL_W] = word_out;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            src_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            src_q       <= src_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule
